pll_lock_supervisor: RTL and testbench



---
 rtl/pll_sup_pkg.sv | 24 ++
 rtl/sync_bit.sv | 24 ++
 rtl/pll_lock_supervisor.sv | 169 ++++++++++++++++
 tb/tb_pll_lock_supervisor.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/pll_sup_pkg.sv
// Shared types and sizing helpers for the PLL lock supervisor.
package pll_sup_pkg;

    // Supervisor states, in the order the PLL normally passes through them.
    typedef enum logic [1:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_QUALIFY,
        S_LOCKED
    } state_e;

    // Width of the shared cycle counter: clog2 of the largest interval it
    // has to measure, plus one bit of headroom.
    function automatic int cnt_width(input int lock_stable,
                                     input int lock_timeout,
                                     input int pll_rst_len);
        int max_val;
        max_val = lock_stable;
        if (lock_timeout > max_val) max_val = lock_timeout;
        if (pll_rst_len > max_val) max_val = pll_rst_len;
        return $clog2(max_val) + 1;
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchroniser for a single asynchronous status bit.
module sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through STAGES flops; cleared on reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Supervises PLL lock on the raw oscillator clock: holds the PLL in reset,
// waits for a synchronised lock, qualifies it for LOCK_STABLE cycles before
// raising pll_ok_o, re-resets the PLL on timeout and counts lock losses.
module pll_lock_supervisor
    import pll_sup_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int LOCK_STABLE  = 1024,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int PLL_RST_LEN  = 16,
    parameter int MAX_RETRIES  = 3,
    parameter int LOSS_W       = 8
) (
    input  logic              clk_in_i,
    input  logic              reset_i,
    input  logic              pll_locked_raw_i,
    input  logic              clr_stat_i,
    output logic              pll_areset_o,
    output logic              pll_ok_o,
    output logic [LOSS_W-1:0] lock_loss_cnt_o,
    output logic              relock_fail_o
);

    localparam int CNT_W   = cnt_width(LOCK_STABLE, LOCK_TIMEOUT, PLL_RST_LEN);
    localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

    localparam logic [CNT_W-1:0]   RST_LAST    = CNT_W'(PLL_RST_LEN - 1);
    localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0]   STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [RETRY_W-1:0] RETRY_MAX   = RETRY_W'(MAX_RETRIES);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [RETRY_W-1:0] retry_q, retry_d;
    logic [RETRY_W-1:0] retry_inc;
    logic               areset_q, areset_d;
    logic               ok_q, ok_d;
    logic [LOSS_W-1:0]  loss_q, loss_d;
    logic               fail_q, fail_d;
    logic               lock_s;

    sync_bit #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .clk_i (clk_in_i),
        .rst_i (reset_i),
        .d_i   (pll_locked_raw_i),
        .q_o   (lock_s)
    );

    // Saturating retry increment used on every lock timeout.
    assign retry_inc = (retry_q == RETRY_MAX) ? retry_q : retry_q + 1'b1;

    // Next-state, counter and statistics logic; outputs follow the next state.
    always_comb begin
        // NOTE: every signal driven here gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        loss_d  = loss_q;
        fail_d  = fail_q;

        case (state_q)
            S_PLL_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_WAIT_LOCK: begin
                if (lock_s) begin
                    // This cycle already counts as the first stable one.
                    if (LOCK_STABLE == 1) begin
                        state_d = S_LOCKED;
                        cnt_d   = '0;
                        retry_d = '0;
                    end else begin
                        state_d = S_QUALIFY;
                        cnt_d   = CNT_W'(1);
                    end
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d = S_PLL_RST;
                    cnt_d   = '0;
                    retry_d = retry_inc;
                    if (retry_inc == RETRY_MAX) begin
                        fail_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_QUALIFY: begin
                if (!lock_s) begin
                    // A glitch before qualification is not a loss; the
                    // timeout window simply restarts.
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                end else if (cnt_q == STABLE_LAST) begin
                    state_d = S_LOCKED;
                    cnt_d   = '0;
                    retry_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            S_LOCKED: begin
                if (!lock_s) begin
                    // The PLL is left running; only a later timeout resets it.
                    state_d = S_WAIT_LOCK;
                    cnt_d   = '0;
                    if (loss_q != '1) begin
                        loss_d = loss_q + 1'b1;
                    end
                end
            end

            default: begin
                state_d = S_PLL_RST;
                cnt_d   = '0;
            end
        endcase

        // Clearing statistics overrides any increment or set this cycle.
        if (clr_stat_i) begin
            loss_d = '0;
            fail_d = 1'b0;
        end

        // Registered outputs track the state being entered, so pll_ok and
        // pll_areset can never be high together.
        areset_d = (state_d == S_PLL_RST);
        ok_d     = (state_d == S_LOCKED);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_in_i) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (reset_i) begin
            state_q  <= S_PLL_RST;
            cnt_q    <= '0;
            retry_q  <= '0;
            areset_q <= 1'b1;
            ok_q     <= 1'b0;
            loss_q   <= '0;
            fail_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            retry_q  <= retry_d;
            areset_q <= areset_d;
            ok_q     <= ok_d;
            loss_q   <= loss_d;
            fail_q   <= fail_d;
        end
    end

    assign pll_areset_o    = areset_q;
    assign pll_ok_o        = ok_q;
    assign lock_loss_cnt_o = loss_q;
    assign relock_fail_o   = fail_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Self-checking bench for pll_lock_supervisor: table-driven segments whose
// expected outputs are queued in a scoreboard and compared when due.
module tb_pll_lock_supervisor;

    localparam int LOSS_W = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic              raw;
    logic              clr;
    logic              areset;
    logic              ok;
    logic [LOSS_W-1:0] loss;
    logic              fail;

    int cyc      = 0;
    int checks   = 0;
    int failures = 0;

    // One stimulus segment: inputs held for len edges, then outputs expected.
    typedef struct {
        string name;
        int    len;
        logic  rst;
        logic  raw;
        logic  clr;
        logic  chk;
        logic  areset;
        logic  ok;
        int    loss;
        logic  fail;
    } vec_t;

    // Scoreboard entry: expected outputs due at a given edge count.
    typedef struct {
        int    cyc;
        string name;
        logic  areset;
        logic  ok;
        int    loss;
        logic  fail;
    } exp_t;

    vec_t tbl[$];
    exp_t sb_q[$];

    pll_lock_supervisor #(
        .SYNC_STAGES  (2),
        .LOCK_STABLE  (8),
        .LOCK_TIMEOUT (32),
        .PLL_RST_LEN  (4),
        .MAX_RETRIES  (3),
        .LOSS_W       (LOSS_W)
    ) dut (
        .clk_in_i         (clk),
        .reset_i          (reset),
        .pll_locked_raw_i (raw),
        .clr_stat_i       (clr),
        .pll_areset_o     (areset),
        .pll_ok_o         (ok),
        .lock_loss_cnt_o  (loss),
        .relock_fail_o    (fail)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic vec_t mk(input string name, input int len,
                                input logic rst, input logic r, input logic c,
                                input logic chk, input logic ar, input logic k,
                                input int ls, input logic f);
        vec_t v;
        v.name = name; v.len = len; v.rst = rst; v.raw = r; v.clr = c;
        v.chk = chk; v.areset = ar; v.ok = k; v.loss = ls; v.fail = f;
        return v;
    endfunction

    task automatic add(input string name, input int len,
                       input logic rst, input logic r, input logic c,
                       input logic ar, input logic k, input int ls, input logic f);
        tbl.push_back(mk(name, len, rst, r, c, 1'b1, ar, k, ls, f));
    endtask

    // Called on a negedge: drive inputs, queue expectations, wait len edges.
    task automatic run_seg(input vec_t v);
        exp_t e;
        reset = v.rst;
        raw   = v.raw;
        clr   = v.clr;
        if (v.chk) begin
            e.cyc = cyc + v.len; e.name = v.name; e.areset = v.areset;
            e.ok = v.ok; e.loss = v.loss; e.fail = v.fail;
            sb_q.push_back(e);
        end
        repeat (v.len) @(negedge clk);
    endtask

    // Compare due scoreboard entries on the falling edge, away from updates.
    always @(negedge clk) begin
        check("ok_and_areset_exclusive", 32'(ok & areset), 32'd0);
        for (int i = sb_q.size() - 1; i >= 0; i--) begin
            if (sb_q[i].cyc == cyc) begin
                check({sb_q[i].name, ".areset"}, 32'(areset), 32'(sb_q[i].areset));
                check({sb_q[i].name, ".ok"},     32'(ok),     32'(sb_q[i].ok));
                check({sb_q[i].name, ".loss"},   32'(loss),   sb_q[i].loss);
                check({sb_q[i].name, ".fail"},   32'(fail),   32'(sb_q[i].fail));
                sb_q.delete(i);
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish, edge %0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int total;
        int exp_loss;

        reset = 1'b1;
        raw   = 1'b0;
        clr   = 1'b0;

        //    name              len rst raw clr ar ok loss fail
        add("rst_hold",          3, 1, 0, 0, 1, 0, 0, 0);
        // Lock after release: areset for 4 cycles, pll_ok 10 edges after raw.
        add("t1_areset_hi",      3, 0, 0, 0, 1, 0, 0, 0);
        add("t1_areset_lo",      1, 0, 0, 0, 0, 0, 0, 0);
        add("t1_wait",          16, 0, 0, 0, 0, 0, 0, 0);
        add("t1_before_ok",      9, 0, 1, 0, 0, 0, 0, 0);
        add("t1_ok_rise",        1, 0, 1, 0, 0, 1, 0, 0);
        // Reset while locked takes effect at the next edge.
        add("rst_locked",        1, 1, 0, 0, 1, 0, 0, 0);
        add("t2_areset_hi",      3, 0, 0, 0, 1, 0, 0, 0);
        add("t2_areset_lo",      1, 0, 0, 0, 0, 0, 0, 0);
        // Lock glitch during qualification: not a loss, qualification restarts.
        add("t2_hi5",            5, 0, 1, 0, 0, 0, 0, 0);
        add("t2_lo3",            3, 0, 0, 0, 0, 0, 0, 0);
        add("t2_before_ok",      9, 0, 1, 0, 0, 0, 0, 0);
        add("t2_ok_rise",        1, 0, 1, 0, 0, 1, 0, 0);
        // One-cycle loss while locked: pll_ok falls 3 edges later, no PLL reset.
        add("t4_drop",           1, 0, 0, 0, 0, 1, 0, 0);
        add("t4_return",         1, 0, 1, 0, 0, 1, 0, 0);
        add("t4_ok_fall",        1, 0, 1, 0, 0, 0, 1, 0);
        add("t4_requal",         7, 0, 1, 0, 0, 0, 1, 0);
        add("t4_ok_rerise",      1, 0, 1, 0, 0, 1, 1, 0);
        // Lock held low: 32-cycle timeout, 4-cycle areset, fail on 3rd timeout.
        add("t3_drop",           3, 0, 0, 0, 0, 0, 2, 0);
        for (int k = 0; k < 3; k++) begin
            add("t3_wait",      31, 0, 0, 0, 0, 0, 2, 0);
            add("t3_rst_start",  1, 0, 0, 0, 1, 0, 2, (k == 2));
            add("t3_rst_hold",   3, 0, 0, 0, 1, 0, 2, (k == 2));
            add("t3_rst_end",    1, 0, 0, 0, 0, 0, 2, (k == 2));
        end
        add("t3_before_ok",      9, 0, 1, 0, 0, 0, 2, 1);
        add("t3_ok_rise",        1, 0, 1, 0, 0, 1, 2, 1);

        @(negedge clk);
        for (int i = 0; i < tbl.size(); i++) begin
            run_seg(tbl[i]);
        end

        // Many loss events: the counter saturates at all-ones.
        total = 2;
        for (int n = 0; n < 260; n++) begin
            total++;
            exp_loss = (total > 255) ? 255 : total;
            run_seg(mk("t5_drop",    1, 0, 0, 0, 0, 0, 0, 0, 0));
            run_seg(mk("t5_return",  1, 0, 1, 0, 0, 0, 0, 0, 0));
            run_seg(mk("t5_ok_fall", 1, 0, 1, 0, 1, 0, 0, exp_loss, 1));
            run_seg(mk("t5_requal",  8, 0, 1, 0, 1, 0, 1, exp_loss, 1));
        end

        // Clear on the very edge that registers a loss: clear wins.
        run_seg(mk("t5c_drop",       1, 0, 0, 0, 0, 0, 0, 0, 0));
        run_seg(mk("t5c_return",     1, 0, 1, 0, 0, 0, 0, 0, 0));
        run_seg(mk("t5_clr_vs_loss", 1, 0, 1, 1, 1, 0, 0, 0, 0));
        run_seg(mk("t5_after_clr",   8, 0, 1, 0, 1, 0, 1, 0, 0));

        // Reset during qualification (cnt=5) restarts from the PLL reset.
        run_seg(mk("t6_drop",        1, 0, 0, 0, 0, 0, 0, 0, 0));
        run_seg(mk("t6_return",      1, 0, 1, 0, 0, 0, 0, 0, 0));
        run_seg(mk("t6_loss",        1, 0, 1, 0, 1, 0, 0, 1, 0));
        run_seg(mk("t6_qual5",       5, 0, 1, 0, 1, 0, 0, 1, 0));
        run_seg(mk("t6_rst",         1, 1, 1, 0, 1, 1, 0, 0, 0));
        run_seg(mk("t6_areset_hi",   3, 0, 1, 0, 1, 1, 0, 0, 0));
        run_seg(mk("t6_areset_lo",   1, 0, 1, 0, 1, 0, 0, 0, 0));
        run_seg(mk("t6_before_ok",   7, 0, 1, 0, 1, 0, 0, 0, 0));
        run_seg(mk("t6_ok_rise",     1, 0, 1, 0, 1, 0, 1, 0, 0));

        repeat (2) @(negedge clk);
        check("scoreboard_drained", 32'(sb_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
